next_line_prefetcher: RTL and testbench



---
 rtl/prefetch_pkg.sv | 35 +++
 rtl/next_line_prefetcher.sv | 122 ++++++++++++
 tb/tb_next_line_prefetcher.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/prefetch_pkg.sv
// ---------------------------------------------------------------------------
// prefetch_pkg
//   Shared types and helpers for the next-line prefetch engine.
//   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package prefetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } pf_state_t;

    localparam int PF_LINE_BYTES  = 32;
    localparam int PF_OFFSET_BITS = $clog2(PF_LINE_BYTES);

    typedef struct packed {
        logic [31:0] addr;
        logic        suppress;
    } next_line_t;

    // The top line of memory has no successor; no wrap to line 0.
    function automatic next_line_t next_line(input logic [31:0] addr);
        next_line_t r;
        r.suppress = &addr[31:PF_OFFSET_BITS];
        r.addr     = {addr[31:PF_OFFSET_BITS] + (32 - PF_OFFSET_BITS)'(1),
                      {PF_OFFSET_BITS{1'b0}}};
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/next_line_prefetcher.sv
// ---------------------------------------------------------------------------
// next_line_prefetcher
//   Fetches the line after each demand miss into a one-entry buffer and
//   offers it to the L1 until installed or cancelled.
//   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module next_line_prefetcher
    import prefetch_pkg::*;
#(
    parameter int s_offset = 5,
    parameter int s_line   = 256,
    parameter int s_count  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               miss_valid,
    input  logic [31:0]        miss_address,
    output logic               pf_pmem_read,
    output logic [31:0]        pf_pmem_address,
    input  logic [s_line-1:0]  pf_pmem_rdata,
    input  logic               pf_pmem_resp,
    output logic               prefetch_ready,
    output logic [s_line-1:0]  prefetch_rdata,
    output logic [31:0]        pf_cline_address,
    input  logic               pf_install,
    input  logic               pf_cancel,
    output logic [s_count-1:0] pf_issued_count,
    output logic [s_count-1:0] pf_installed_count
);

    pf_state_t   r_state;
    logic        r_pend_valid;
    logic [31:0] r_pend_addr;

    next_line_t  w_nl;
    logic        w_trig;
    logic        w_dup;
    logic        w_exit;

    // pf_pmem_address holds the active line through both FETCH and HOLD.
    always_comb begin
        w_nl   = next_line(miss_address);
        w_trig = miss_valid && !w_nl.suppress;
        w_dup  = (w_nl.addr[31:s_offset] == pf_pmem_address[31:s_offset]);
        w_exit = pf_install || pf_cancel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state            <= IDLE;
            r_pend_valid       <= 1'b0;
            r_pend_addr        <= '0;
            pf_pmem_read       <= 1'b0;
            pf_pmem_address    <= '0;
            prefetch_ready     <= 1'b0;
            prefetch_rdata     <= '0;
            pf_cline_address   <= '0;
            pf_issued_count    <= '0;
            pf_installed_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_trig) begin
                        pf_pmem_address <= w_nl.addr;
                        pf_pmem_read    <= 1'b1;
                        r_state         <= FETCH;
                    end
                end

                FETCH: begin
                    if (w_trig && !w_dup) begin
                        r_pend_valid <= 1'b1;
                        r_pend_addr  <= w_nl.addr;
                    end
                    if (pf_pmem_resp) begin
                        prefetch_rdata   <= pf_pmem_rdata;
                        pf_cline_address <= pf_pmem_address;
                        pf_pmem_read     <= 1'b0;
                        prefetch_ready   <= 1'b1;
                        if (pf_issued_count != '1)
                            pf_issued_count <= pf_issued_count + s_count'(1);
                        r_state          <= HOLD;
                    end
                end

                HOLD: begin
                    if (w_exit) begin
                        prefetch_ready <= 1'b0;
                        if (pf_install && (pf_installed_count != '1))
                            pf_installed_count <= pf_installed_count + s_count'(1);
                        // A miss arriving on the exit cycle wins over pending.
                        if (w_trig) begin
                            pf_pmem_address <= w_nl.addr;
                            pf_pmem_read    <= 1'b1;
                            r_state         <= FETCH;
                        end else if (r_pend_valid) begin
                            pf_pmem_address <= r_pend_addr;
                            pf_pmem_read    <= 1'b1;
                            r_pend_valid    <= 1'b0;
                            r_state         <= FETCH;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else if (w_trig && !w_dup) begin
                        r_pend_valid <= 1'b1;
                        r_pend_addr  <= w_nl.addr;
                    end
                end

                default: begin
                    r_state      <= IDLE;
                    pf_pmem_read <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_next_line_prefetcher.sv
// ---------------------------------------------------------------------------
// tb_next_line_prefetcher
//   Directed vectors for next_line_prefetcher; a narrow-counter twin checks
//   saturation without thousands of installs.
//   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_next_line_prefetcher;

    logic         clk = 1'b0;
    logic         rst;
    logic         miss_valid;
    logic [31:0]  miss_address;
    logic [255:0] pf_pmem_rdata;
    logic         pf_pmem_resp;
    logic         pf_install;
    logic         pf_cancel;

    logic         pf_pmem_read;
    logic [31:0]  pf_pmem_address;
    logic         prefetch_ready;
    logic [255:0] prefetch_rdata;
    logic [31:0]  pf_cline_address;
    logic [15:0]  pf_issued_count;
    logic [15:0]  pf_installed_count;

    logic         s_pmem_read;
    logic [31:0]  s_pmem_address;
    logic         s_ready;
    logic [255:0] s_rdata;
    logic [31:0]  s_cline_address;
    logic [3:0]   s_issued_count;
    logic [3:0]   s_installed_count;

    int n_vec = 0;
    int n_err = 0;

    logic [255:0] c_data_a;
    logic [255:0] c_data_b;
    logic [255:0] c_data_c;

    next_line_prefetcher #(.s_offset(5), .s_line(256), .s_count(16)) u_dut (
        .clk(clk), .rst(rst),
        .miss_valid(miss_valid), .miss_address(miss_address),
        .pf_pmem_read(pf_pmem_read), .pf_pmem_address(pf_pmem_address),
        .pf_pmem_rdata(pf_pmem_rdata), .pf_pmem_resp(pf_pmem_resp),
        .prefetch_ready(prefetch_ready), .prefetch_rdata(prefetch_rdata),
        .pf_cline_address(pf_cline_address),
        .pf_install(pf_install), .pf_cancel(pf_cancel),
        .pf_issued_count(pf_issued_count),
        .pf_installed_count(pf_installed_count)
    );

    next_line_prefetcher #(.s_offset(5), .s_line(256), .s_count(4)) u_sat (
        .clk(clk), .rst(rst),
        .miss_valid(miss_valid), .miss_address(miss_address),
        .pf_pmem_read(s_pmem_read), .pf_pmem_address(s_pmem_address),
        .pf_pmem_rdata(pf_pmem_rdata), .pf_pmem_resp(pf_pmem_resp),
        .prefetch_ready(s_ready), .prefetch_rdata(s_rdata),
        .pf_cline_address(s_cline_address),
        .pf_install(pf_install), .pf_cancel(pf_cancel),
        .pf_issued_count(s_issued_count),
        .pf_installed_count(s_installed_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic miss(input logic [31:0] a);
        miss_valid   = 1'b1;
        miss_address = a;
        step();
        miss_valid   = 1'b0;
    endtask

    task automatic resp(input logic [255:0] d);
        pf_pmem_resp  = 1'b1;
        pf_pmem_rdata = d;
        step();
        pf_pmem_resp  = 1'b0;
    endtask

    task automatic hold_exit(input logic inst, input logic canc);
        pf_install = inst;
        pf_cancel  = canc;
        step();
        pf_install = 1'b0;
        pf_cancel  = 1'b0;
    endtask

    initial begin
        c_data_a = {32{8'hA5}};
        c_data_b = {8{32'h1234_5678}};
        c_data_c = {16{16'hBEEF}};
        rst = 1'b1; miss_valid = 1'b0; miss_address = '0;
        pf_pmem_rdata = '0; pf_pmem_resp = 1'b0;
        pf_install = 1'b0; pf_cancel = 1'b0;
        step(); step();
        rst = 1'b0;

        check("rst_read",    {255'd0, pf_pmem_read},  256'd0);
        check("rst_ready",   {255'd0, prefetch_ready}, 256'd0);
        check("rst_paddr",   pf_pmem_address,  256'd0);
        check("rst_caddr",   pf_cline_address, 256'd0);
        check("rst_rdata",   prefetch_rdata,   256'd0);
        check("rst_issued",  pf_issued_count,  256'd0);
        check("rst_inst",    pf_installed_count, 256'd0);

        // Basic fetch
        miss(32'h0000_1040);
        check("t1_read",  {255'd0, pf_pmem_read}, 256'd1);
        check("t1_paddr", pf_pmem_address, 256'h1060);
        step(); step(); step();
        check("t1_read_held", {255'd0, pf_pmem_read}, 256'd1);
        resp(c_data_a);
        check("t1_read_drop", {255'd0, pf_pmem_read}, 256'd0);
        check("t1_ready", {255'd0, prefetch_ready}, 256'd1);
        check("t1_rdata", prefetch_rdata, c_data_a);
        check("t1_caddr", pf_cline_address, 256'h1060);
        check("t1_issued", pf_issued_count, 256'd1);
        step();
        check("t1_ready_stable", {255'd0, prefetch_ready}, 256'd1);
        hold_exit(1'b1, 1'b0);
        check("t1_ready_off", {255'd0, prefetch_ready}, 256'd0);
        check("t1_idle_read", {255'd0, pf_pmem_read}, 256'd0);
        check("t1_inst", pf_installed_count, 256'd1);

        // Top-of-memory suppression
        miss(32'hFFFF_FFE4);
        for (int i = 0; i < 10; i++) begin
            check("t2_no_read", {255'd0, pf_pmem_read}, 256'd0);
            step();
        end
        check("t2_issued", pf_issued_count, 256'd1);
        check("t2_inst", pf_installed_count, 256'd1);

        // Pending overwrite and duplicate drop
        miss(32'h0000_2000);
        check("t3_paddr0", pf_pmem_address, 256'h2020);
        miss(32'h0000_3000);
        miss(32'h0000_4000);
        miss(32'h0000_2004);
        check("t3_read_held", {255'd0, pf_pmem_read}, 256'd1);
        check("t3_paddr_held", pf_pmem_address, 256'h2020);
        resp(c_data_b);
        check("t3_caddr0", pf_cline_address, 256'h2020);
        hold_exit(1'b1, 1'b0);
        check("t3_ready_off", {255'd0, prefetch_ready}, 256'd0);
        check("t3_pend_read", {255'd0, pf_pmem_read}, 256'd1);
        check("t3_pend_addr", pf_pmem_address, 256'h4020);
        resp(c_data_c);
        check("t3_caddr1", pf_cline_address, 256'h4020);
        check("t3_rdata1", prefetch_rdata, c_data_c);
        hold_exit(1'b1, 1'b0);
        check("t3_no_more", {255'd0, pf_pmem_read}, 256'd0);
        check("t3_issued", pf_issued_count, 256'd3);
        check("t3_inst", pf_installed_count, 256'd3);

        // Cancel, collision, stray install, miss on exit cycle
        miss(32'h0000_5000);
        resp(c_data_a);
        hold_exit(1'b0, 1'b1);
        check("t4_cancel_ready", {255'd0, prefetch_ready}, 256'd0);
        check("t4_cancel_inst", pf_installed_count, 256'd3);
        check("t4_cancel_read", {255'd0, pf_pmem_read}, 256'd0);
        miss(32'h0000_6000);
        resp(c_data_b);
        hold_exit(1'b1, 1'b1);
        check("t4_both_inst", pf_installed_count, 256'd4);
        check("t4_both_ready", {255'd0, prefetch_ready}, 256'd0);
        hold_exit(1'b1, 1'b0);
        check("t4_stray_inst", pf_installed_count, 256'd4);
        miss(32'h0000_7000);
        resp(c_data_c);
        miss_valid = 1'b1; miss_address = 32'h0000_8000;
        hold_exit(1'b1, 1'b0);
        miss_valid = 1'b0;
        check("t4_exit_read", {255'd0, pf_pmem_read}, 256'd1);
        check("t4_exit_addr", pf_pmem_address, 256'h8020);
        check("t4_exit_inst", pf_installed_count, 256'd5);
        resp(c_data_a);
        hold_exit(1'b1, 1'b0);
        check("t4_issued", pf_issued_count, 256'd7);
        check("t4_inst", pf_installed_count, 256'd6);

        // Reset mid-FETCH
        miss(32'h0000_9000);
        check("t5_read", {255'd0, pf_pmem_read}, 256'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_read_off", {255'd0, pf_pmem_read}, 256'd0);
        check("t5_paddr", pf_pmem_address, 256'd0);
        check("t5_issued", pf_issued_count, 256'd0);
        check("t5_inst", pf_installed_count, 256'd0);
        resp(c_data_b);
        check("t5_stale_ready", {255'd0, prefetch_ready}, 256'd0);
        check("t5_stale_issued", pf_issued_count, 256'd0);

        // Saturation on the 4-bit twin, plain counting on the 16-bit DUT
        for (int i = 0; i < 17; i++) begin
            miss(32'h0001_0000 + 32'(i) * 32'h40);
            resp(c_data_c);
            hold_exit(1'b1, 1'b0);
        end
        check("t6_sat_inst", s_installed_count, 256'hF);
        check("t6_sat_issued", s_issued_count, 256'hF);
        check("t6_wide_inst", pf_installed_count, 256'd17);
        check("t6_wide_issued", pf_issued_count, 256'd17);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
